// File: rtl/sm4_pkg.sv
// sm4_pkg: SM4 S-box, linear transform and shared types for the crypt engine
package sm4_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ROUNDS = 32;
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  function automatic logic [7:0] sbox8(input logic [7:0] x);
    return SBOX[8*(255-int'(x)) +: 8];
  endfunction
  function automatic word_t rotl(input word_t w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction
  function automatic word_t sm4_L(input word_t b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction
endpackage

// File: rtl/sm4_round.sv
// sm4_round: one combinational SM4 round, shifts the 4-word window by one
module sm4_round
  import sm4_pkg::*;
(
  input  logic [127:0] x_i,
  input  logic [31:0]  rk_i,
  output logic [127:0] x_o
);
  word_t t, s;
  always_comb begin
    t = x_i[95:64] ^ x_i[63:32] ^ x_i[31:0] ^ rk_i;
    s = {sbox8(t[31:24]), sbox8(t[23:16]), sbox8(t[15:8]), sbox8(t[7:0])};
    x_o = {x_i[95:0], x_i[127:96] ^ sm4_L(s)};
  end
endmodule

// File: rtl/sm4_crypt_engine.sv
// sm4_crypt_engine: iterative SM4 encrypt/decrypt core, UNROLL rounds per clock,
// valid/ready on both sides with output backpressure.
module sm4_crypt_engine
  import sm4_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          CLK_i,
  input  logic          RST_N_i,
  input  logic [1023:0] RK_i,
  input  logic          MODE_i,
  input  logic [127:0]  DAT_i,
  input  logic          IN_VALID_i,
  output logic          IN_READY_o,
  output logic [127:0]  DAT_o,
  output logic          OUT_VALID_o,
  input  logic          OUT_READY_i,
  output logic          BUSY_o
);
  localparam int STEPS = ROUNDS / UNROLL;
  localparam int CNT_W = $clog2(ROUNDS / UNROLL) + 1;
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16 || UNROLL == 32)) begin : g_bad
    $error("sm4_crypt_engine: UNROLL must be 1, 2, 4, 8, 16 or 32");
  end
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       x_q, x_d;
  logic               mode_q, mode_d;
  logic               accept, handoff;
  word_t              rk_w [ROUNDS];
  logic [127:0]       ch [UNROLL+1];
  for (genvar i = 0; i < ROUNDS; i++) begin : g_rk
    assign rk_w[i] = RK_i[1023-32*i -: 32];
  end
  assign ch[0] = x_q;
  // decrypt walks the keys backwards: 31-r is the bitwise inverse of a 5-bit r
  for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
    logic [4:0] r;
    assign r = 5'(int'(cnt_q) * UNROLL + k);
    sm4_round u_round (.x_i(ch[k]), .rk_i(rk_w[mode_q ? ~r : r]), .x_o(ch[k+1]));
  end
  assign IN_READY_o  = state_q == IDLE || (state_q == DONE && OUT_READY_i);
  assign OUT_VALID_o = state_q == DONE;
  assign BUSY_o      = state_q == RUN;
  assign DAT_o       = OUT_VALID_o ? {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]} : '0;
  assign accept      = IN_VALID_i && IN_READY_o;
  assign handoff     = OUT_VALID_o && OUT_READY_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    mode_d  = mode_q;
    if (state_q == RUN) begin
      x_d     = ch[UNROLL];
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(STEPS - 1) ? DONE : RUN;
    end else if (accept) begin
      x_d     = DAT_i;
      mode_d  = MODE_i;
      cnt_d   = '0;
      state_d = RUN;
    end else if (handoff) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: tb/tb_sm4_crypt_engine.sv
// tb_sm4_crypt_engine: directed KATs, handshake/reset scenarios and random
// blocks/keys checked against a word-array SM4 model with its own key schedule.
module tb_sm4_crypt_engine;
  localparam int U   = 1;
  localparam int LAT = 32 / U;
  localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
  logic          CLK_i = 1'b0;
  logic          RST_N_i = 1'b0;
  logic [1023:0] RK_i = '0;
  logic          MODE_i = 1'b0;
  logic [127:0]  DAT_i = '0;
  logic          IN_VALID_i = 1'b0;
  logic          IN_READY_o;
  logic [127:0]  DAT_o;
  logic          OUT_VALID_o;
  logic          OUT_READY_i = 1'b1;
  logic          BUSY_o;
  int            checks = 0;
  int            failures = 0;
  logic [31:0]   rk_cur [32];

  sm4_crypt_engine #(.UNROLL(U)) dut (
    .CLK_i(CLK_i), .RST_N_i(RST_N_i), .RK_i(RK_i), .MODE_i(MODE_i), .DAT_i(DAT_i),
    .IN_VALID_i(IN_VALID_i), .IN_READY_o(IN_READY_o), .DAT_o(DAT_o),
    .OUT_VALID_o(OUT_VALID_o), .OUT_READY_i(OUT_READY_i), .BUSY_o(BUSY_o)
  );

  always #5 CLK_i = ~CLK_i;

  function automatic logic [31:0] rol(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] tf(input logic [31:0] x, input bit ks);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sm4_pkg::sbox8(x[8*j +: 8]);
    return ks ? b ^ rol(b, 13) ^ rol(b, 23) : b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [127:0] ref_crypt(input logic [127:0] blk, input bit dec);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int r = 0; r < 32; r++)
      x[r+4] = x[r] ^ tf(x[r+1] ^ x[r+2] ^ x[r+3] ^ (dec ? rk_cur[31-r] : rk_cur[r]), 1'b0);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic drive_key();
    for (int i = 0; i < 32; i++) RK_i[1023-32*i -: 32] = rk_cur[i];
  endtask

  task automatic load_std_key(input logic [127:0] mk);
    logic [31:0] fk [4];
    logic [31:0] kk [36];
    logic [31:0] ck;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) kk[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'((4*i + j) * 7)};
      kk[i+4] = kk[i] ^ tf(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck, 1'b1);
      rk_cur[i] = kk[i+4];
    end
    drive_key();
  endtask

  task automatic load_rnd_key();
    for (int i = 0; i < 32; i++) rk_cur[i] = $urandom;
    drive_key();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  // accepts one block, scrambles the inputs, then waits for OUT_VALID_o
  task automatic run_job(input logic [127:0] blk, input bit md, input logic [127:0] exp, input string tag);
    int n = 0;
    IN_VALID_i = 1'b1;
    DAT_i = blk;
    MODE_i = md;
    tick();
    IN_VALID_i = 1'b0;
    DAT_i = {$urandom, $urandom, $urandom, $urandom};
    MODE_i = ~md;
    while (!OUT_VALID_o && n < 4 * LAT + 8) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    chk({tag, "_dat"}, DAT_o, exp);
  endtask

  initial begin
    logic [127:0] blk, exp;
    bit md, ok;
    int n;
    load_std_key(MK);
    repeat (3) tick();
    chk("rst_valid", 128'(OUT_VALID_o), 128'(0));
    chk("rst_busy", 128'(BUSY_o), 128'(0));
    chk("rst_dat", DAT_o, 128'(0));
    RST_N_i = 1'b1;
    #1;
    chk("rst_ready", 128'(IN_READY_o), 128'(1));

    run_job(PT, 1'b0, CT, "enc");
    chk("enc_busy_lo", 128'(BUSY_o), 128'(0));
    tick();
    chk("enc_drop", {127'(0), OUT_VALID_o}, 128'(0));
    chk("enc_dat0", DAT_o, 128'(0));
    run_job(CT, 1'b1, PT, "dec");
    tick();

    OUT_READY_i = 1'b0;
    run_job(PT, 1'b0, CT, "bp");
    IN_VALID_i = 1'b1;
    DAT_i = CT;
    ok = 1'b1;
    repeat (10) begin
      tick();
      ok &= OUT_VALID_o && DAT_o === CT && !IN_READY_o && !BUSY_o;
    end
    chk("bp_hold", 128'(ok), 128'(1));
    IN_VALID_i = 1'b0;
    OUT_READY_i = 1'b1;
    #1;
    chk("bp_ready", 128'(IN_READY_o), 128'(1));
    tick();
    chk("bp_done", 128'(OUT_VALID_o), 128'(0));
    chk("bp_idle_busy", 128'(BUSY_o), 128'(0));

    IN_VALID_i = 1'b1;
    DAT_i = PT;
    MODE_i = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      DAT_i = j[0] ? PT : CT;
      MODE_i = ~j[0];
      if (j == 3) IN_VALID_i = 1'b0;
      n = 0;
      while (!OUT_VALID_o && n < 4 * LAT + 8) begin
        tick();
        n++;
      end
      chk("b2b_lat", 128'(n), 128'(LAT));
      chk("b2b_dat", DAT_o, j[0] ? PT : CT);
      chk("b2b_ready", 128'(IN_READY_o), 128'(1));
      tick();
      chk("b2b_busy", 128'(BUSY_o), 128'(j < 3));
    end

    IN_VALID_i = 1'b1;
    DAT_i = PT;
    MODE_i = 1'b0;
    tick();
    IN_VALID_i = 1'b0;
    repeat (5) tick();
    chk("rst_mid_busy", 128'(BUSY_o), 128'(1));
    #2 RST_N_i = 1'b0;
    #1;
    chk("rst_mid_out", {OUT_VALID_o, BUSY_o, DAT_o[125:0]}, 128'(0));
    tick();
    RST_N_i = 1'b1;
    ok = 1'b1;
    repeat (LAT + 4) begin
      tick();
      ok &= !OUT_VALID_o;
    end
    chk("rst_nopulse", 128'(ok), 128'(1));
    run_job(CT, 1'b1, PT, "rst_dec");
    tick();

    for (int t = 0; t < 8; t++) begin
      if (t[0]) load_rnd_key(); else load_std_key({$urandom, $urandom, $urandom, $urandom});
      blk = {$urandom, $urandom, $urandom, $urandom};
      md = 1'($urandom_range(0, 1));
      exp = ref_crypt(blk, md);
      OUT_READY_i = 1'($urandom_range(0, 1));
      run_job(blk, md, exp, "rnd");
      if (!OUT_READY_i) begin
        repeat ($urandom_range(1, 5)) tick();
        chk("rnd_stall", DAT_o, exp);
        OUT_READY_i = 1'b1;
      end
      tick();
      chk("rnd_drop", 128'(OUT_VALID_o), 128'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
